// File: rtl/boton_eventos_if.sv
// Button-level inputs and event outputs of boton_eventos, grouped as one bundle.
// The debounce side acts as master; boton_eventos is the slave.
interface boton_eventos_if;
  logic reset_db, test_db, action_db, cancel_db, left_db, right_db;
  logic reset_long, test_long, test_short;
  logic action_press, cancel_press, left_press, right_press;
  logic reset_pending;

  modport master (
    output reset_db, test_db, action_db, cancel_db, left_db, right_db,
    input  reset_long, test_long, test_short, action_press, cancel_press,
           left_press, right_press, reset_pending
  );
  modport slave (
    input  reset_db, test_db, action_db, cancel_db, left_db, right_db,
    output reset_long, test_long, test_short, action_press, cancel_press,
           left_press, right_press, reset_pending
  );
endinterface

// File: rtl/boton_eventos.sv
// Debounced button levels -> one-cycle events (press / long-hold / short-release).
// Optional left/right auto-repeat is enabled by defining BOTON_REPEAT_EN.

// Hold FSM for one button. aux is the short-release pulse when SHORT_EV=1,
// otherwise the COUNT-state level.
module boton_hold #(
  parameter int unsigned HOLD_CYCLES = 250_000_000,
  parameter int unsigned CNT_W       = 28,
  parameter bit          SHORT_EV    = 1'b0
)(
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic mask,
  output logic long_p,
  output logic aux
);
  typedef enum logic [1:0] {IDLE, COUNT, WAIT_REL} st_t;
  st_t              st;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= WAIT_REL;
      cnt    <= '0;
      long_p <= 1'b0;
      aux    <= 1'b0;
    end else begin
      long_p <= 1'b0;
      aux    <= 1'b0;
      case (st)
        IDLE: if (btn) begin
          st  <= COUNT;
          cnt <= CNT_W'(1);
          if (!SHORT_EV) aux <= 1'b1;
        end
        COUNT: begin
          if (!btn) begin
            st  <= IDLE;
            cnt <= '0;
            if (SHORT_EV) aux <= ~mask;
          end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            // Counter stops here; WAIT_REL holds it until release.
            st     <= WAIT_REL;
            long_p <= ~mask;
          end else begin
            cnt <= cnt + 1'b1;
            if (!SHORT_EV) aux <= 1'b1;
          end
        end
        WAIT_REL: if (!btn) begin
          st  <= IDLE;
          cnt <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module boton_eventos #(
  parameter int unsigned HOLD_CYCLES   = 250_000_000,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned CNT_W         = 28
)(
  input  logic            clk,
  input  logic            rst_n,
  boton_eventos_if.slave  bus
);
  localparam int NUM_HOLD = 2;

  // The reset FSM is in COUNT/WAIT_REL after an edge exactly when reset_db
  // was sampled high at that edge, so the raw level is the registered mask.
  logic mask;
  assign mask = bus.reset_db;

  logic [NUM_HOLD-1:0] hold_btn, hold_mask, hold_long, hold_aux;
  assign hold_btn  = {bus.test_db, bus.reset_db};
  assign hold_mask = {mask, 1'b0};

  generate
    for (genvar i = 0; i < NUM_HOLD; i++) begin : g_hold
      boton_hold #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W),
        .SHORT_EV    (i == 1)
      ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (hold_btn[i]),
        .mask   (hold_mask[i]),
        .long_p (hold_long[i]),
        .aux    (hold_aux[i])
      );
    end
  endgenerate

  assign bus.reset_long    = hold_long[0];
  assign bus.reset_pending = hold_aux[0];
  assign bus.test_long     = hold_long[1];
  assign bus.test_short    = hold_aux[1];

  // Press buttons: [3]=action [2]=cancel [1]=left [0]=right
  logic [3:0] btn4, prev, rise;
  logic [1:0] lr_in, rep;
  logic       both;
  assign btn4  = {bus.action_db, bus.cancel_db, bus.left_db, bus.right_db};
  assign rise  = btn4 & ~prev;
  assign lr_in = btn4[1:0];
  assign both  = rise[1] & rise[0];

`ifdef BOTON_REPEAT_EN
  generate
    for (genvar i = 0; i < 2; i++) begin : g_rep
      logic [CNT_W-1:0] rcnt, tgt;
      logic             phase, blk;
      assign tgt    = phase ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
      assign rep[i] = lr_in[i] & ~rise[i] & ~blk & (rcnt == tgt);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt  <= '0;
          phase <= 1'b0;
          blk   <= 1'b0;
        end else if (!lr_in[i]) begin
          rcnt  <= '0;
          phase <= 1'b0;
          blk   <= 1'b0;
        end else if (rise[i]) begin
          // An ambiguous double press locks this direction until release.
          rcnt  <= CNT_W'(1);
          phase <= 1'b0;
          blk   <= both;
        end else if (!blk) begin
          if (rcnt == tgt) begin
            rcnt  <= '0;
            phase <= 1'b1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
      end
    end
  endgenerate
`else
  assign rep = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev             <= '1;
      bus.action_press <= 1'b0;
      bus.cancel_press <= 1'b0;
      bus.left_press   <= 1'b0;
      bus.right_press  <= 1'b0;
    end else begin
      prev             <= btn4;
      bus.action_press <= rise[3] & ~mask;
      bus.cancel_press <= rise[2] & ~mask;
      bus.left_press   <= ((rise[1] & ~both) | rep[1]) & ~mask;
      bus.right_press  <= ((rise[0] & ~both) | rep[0]) & ~mask;
    end
  end
endmodule

// File: tb/tb_boton_eventos.sv
// Directed bench for boton_eventos with HOLD_CYCLES=10, REPEAT_DELAY=8, REPEAT_PERIOD=4.
module tb_boton_eventos;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  boton_eventos_if bus();

  boton_eventos #(
    .HOLD_CYCLES   (10),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // inputs {reset, test, action, cancel, left, right}
  localparam logic [5:0] B_0 = 6'b000000, B_RST = 6'b100000, B_TST = 6'b010000,
                         B_ACT = 6'b001000, B_CAN = 6'b000100, B_L = 6'b000010,
                         B_R = 6'b000001;
  // outputs {reset_long, test_long, test_short, action, cancel, left, right, reset_pending}
  localparam logic [7:0] O_0 = 8'h00, O_RL = 8'h80, O_TL = 8'h40, O_TS = 8'h20,
                         O_AP = 8'h10, O_CP = 8'h08, O_LP = 8'h04, O_RP = 8'h02,
                         O_PEND = 8'h01;
`ifdef BOTON_REPEAT_EN
  localparam logic [7:0] RP_X = O_RP;
`else
  localparam logic [7:0] RP_X = O_0;
`endif

  typedef struct {
    logic [5:0] btn;
    int         reps;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(input logic [5:0] b, input int reps, input logic [7:0] e);
    vec_t v;
    v.btn = b; v.reps = reps; v.exp = e;
    vt.push_back(v);
  endfunction

  function automatic logic [7:0] outs();
    return {bus.reset_long, bus.test_long, bus.test_short, bus.action_press,
            bus.cancel_press, bus.left_press, bus.right_press, bus.reset_pending};
  endfunction

  task automatic drive(input logic [5:0] b);
    {bus.reset_db, bus.test_db, bus.action_db, bus.cancel_db, bus.left_db, bus.right_db} = b;
  endtask

  task automatic check(input logic [7:0] e, input string tag);
    logic [7:0] got;
    got = outs();
    n_chk++;
    if (got === e) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, e);
  endtask

  task automatic step(input logic [5:0] b, input logic [7:0] e, input string tag);
    drive(b);
    @(posedge clk);
    #1;
    check(e, tag);
  endtask

  initial begin
    drive(B_0);
    // action press, held 20 cycles
    add(B_0, 3, O_0);
    add(B_ACT, 1, O_AP);   add(B_ACT, 19, O_0);  add(B_0, 2, O_0);
    // test short
    add(B_TST, 5, O_0);    add(B_0, 1, O_TS);    add(B_0, 2, O_0);
    // test long, no short on release
    add(B_TST, 9, O_0);    add(B_TST, 1, O_TL);  add(B_TST, 5, O_0);
    add(B_0, 2, O_0);
    // reset hold 30 cycles with action pressed inside the window
    add(B_RST | B_ACT, 1, O_PEND); add(B_RST | B_ACT, 2, O_PEND);
    add(B_RST, 6, O_PEND); add(B_RST, 1, O_RL);  add(B_RST, 20, O_0);
    add(B_0, 2, O_0);
    // reset and test together: test_long masked
    add(B_RST | B_TST, 9, O_PEND); add(B_RST | B_TST, 1, O_RL);
    add(B_RST | B_TST, 2, O_0);    add(B_0, 2, O_0);
    // cancel
    add(B_CAN, 1, O_CP);   add(B_CAN, 3, O_0);   add(B_0, 1, O_0);
    // left+right same cycle suppressed, then left alone
    add(B_L | B_R, 6, O_0); add(B_0, 1, O_0);
    add(B_L, 1, O_LP);     add(B_L, 3, O_0);     add(B_0, 1, O_0);
    // right held 20 cycles: repeats only when enabled
    add(B_R, 1, O_RP);     add(B_R, 6, O_0);     add(B_R, 1, RP_X);
    add(B_R, 3, O_0);      add(B_R, 1, RP_X);    add(B_R, 3, O_0);
    add(B_R, 1, RP_X);     add(B_R, 3, O_0);     add(B_R, 1, RP_X);
    add(B_0, 2, O_0);

    repeat (3) @(posedge clk);
    #1;
    check(O_0, "reset_state");
    rst_n = 1'b1;

    foreach (vt[k])
      for (int r = 0; r < vt[k].reps; r++)
        step(vt[k].btn, vt[k].exp, $sformatf("vec%0d.%0d", k, r));

    // rst_n mid-hold: no partial event afterwards
    for (int r = 0; r < 4; r++) step(B_RST | B_TST, O_PEND, $sformatf("pre_rst%0d", r));
    #2 rst_n = 1'b0;
    #1 check(O_0, "async_clear");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 40; r++) step(B_RST | B_TST, O_0, $sformatf("held_after_rst%0d", r));
    for (int r = 0; r < 3; r++) step(B_0, O_0, $sformatf("release_after_rst%0d", r));
    step(B_ACT, O_AP, "press_after_rst");
    step(B_0, O_0, "idle_after_rst");

    // action held through reset: no event until re-pressed
    drive(B_ACT);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 5; r++) step(B_ACT, O_0, $sformatf("act_held_rst%0d", r));
    step(B_0, O_0, "act_release");
    step(B_ACT, O_AP, "act_repress");
    step(B_0, O_0, "act_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
